// File: rtl/lpddr5_cmd_scheduler.sv
// LPDDR5 command scheduler: turns single read/write requests into PRE/ACT/RD/WR sequences with
// per-bank open-row tracking and periodic all-bank refresh. Define LPDDR5_SCHED_CLOSED_PAGE_EN for closed-page policy.

package lpddr5_sched_pkg;
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } dram_cmd_t;
endpackage

module lpddr5_cmd_scheduler
    import lpddr5_sched_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BANK_BITS   = 3,
    parameter int ROW_LSB     = 10,
    parameter int REFI_CYCLES = 3900
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output dram_cmd_t             dram_cmd,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic                  dram_ready
);

    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int ROW_W     = ADDR_WIDTH - ROW_LSB;
    localparam int CNT_W     = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_CAS,
        S_WAIT,
        S_RPRE,
        S_REF
    } state_t;

    state_t                  state_reg;
    state_t                  ret_reg;
    logic                    wait_first_reg;
    logic                    cas_pending_reg;
    logic                    wr_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [NUM_BANKS-1:0]    bank_open_reg;
    logic [ROW_W-1:0]        row_tag_reg [NUM_BANKS];
    logic [CNT_W-1:0]        refi_cnt_reg;
    logic                    ref_pending_reg;

    logic [BANK_BITS-1:0]    req_bank;
    logic [ROW_W-1:0]        req_row;
    logic [BANK_BITS-1:0]    cur_bank;
    logic [ROW_W-1:0]        cur_row;
    logic [NUM_BANKS-1:0]    row_match;
    logic [BANK_BITS-1:0]    low_bank;
    logic [NUM_BANKS-1:0]    low_mask;
    logic                    any_open;
    logic                    ref_expire;
    logic                    ref_clr;
    logic                    ref_pending_next;

    assign req_bank = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign req_row  = req_addr[ADDR_WIDTH-1:ROW_LSB];
    assign cur_bank = addr_reg[ADDR_WIDTH-1 -: BANK_BITS];
    assign cur_row  = addr_reg[ADDR_WIDTH-1:ROW_LSB];
    assign any_open = |bank_open_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign row_match[gi] = bank_open_reg[gi] && (row_tag_reg[gi] == req_row);
        end
    endgenerate

    // Refresh drains open banks in ascending index order.
    always_comb begin
        low_bank = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (bank_open_reg[i]) low_bank = BANK_BITS'(i);
        end
    end

    assign low_mask = NUM_BANKS'(1) << low_bank;

    // A coincident expiry wins over the REF clear so a refresh interval is never lost.
    assign ref_expire       = (refi_cnt_reg == '0);
    assign ref_clr          = (state_reg == S_REF);
    assign ref_pending_next = ref_expire || (ref_pending_reg && !ref_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            ret_reg         <= S_IDLE;
            wait_first_reg  <= 1'b0;
            cas_pending_reg <= 1'b0;
            wr_reg          <= 1'b0;
            addr_reg        <= '0;
            bank_open_reg   <= '0;
            refi_cnt_reg    <= CNT_W'(REFI_CYCLES - 1);
            ref_pending_reg <= 1'b0;
            req_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_write       <= 1'b0;
            dram_cmd        <= CMD_NOP;
            dram_addr       <= '0;
        end else begin
            rsp_valid       <= 1'b0;
            ref_pending_reg <= ref_pending_next;
            refi_cnt_reg    <= ref_expire ? CNT_W'(REFI_CYCLES - 1) : refi_cnt_reg - 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (ref_pending_reg && dram_ready) begin
                        req_ready <= 1'b0;
                        state_reg <= any_open ? S_RPRE : S_REF;
                    end else if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        wr_reg    <= req_write;
                        addr_reg  <= req_addr;
                        if (!bank_open_reg[req_bank])
                            state_reg <= S_ACT;
                        else if (row_match[req_bank])
                            state_reg <= S_CAS;
                        else
                            state_reg <= S_PRE;
                    end else begin
                        req_ready <= !ref_pending_next && dram_ready;
                    end
                end
                S_PRE: begin
                    dram_cmd                <= CMD_PRE;
                    dram_addr               <= {cur_bank, {(ADDR_WIDTH-BANK_BITS){1'b0}}};
                    bank_open_reg[cur_bank] <= 1'b0;
`ifdef LPDDR5_SCHED_CLOSED_PAGE_EN
                    ret_reg                 <= S_IDLE;
`else
                    ret_reg                 <= S_ACT;
`endif
                    wait_first_reg          <= 1'b1;
                    state_reg               <= S_WAIT;
                end
                S_ACT: begin
                    dram_cmd                <= CMD_ACT;
                    dram_addr               <= addr_reg;
                    bank_open_reg[cur_bank] <= 1'b1;
                    row_tag_reg[cur_bank]   <= cur_row;
                    ret_reg                 <= S_CAS;
                    wait_first_reg          <= 1'b1;
                    state_reg               <= S_WAIT;
                end
                S_CAS: begin
                    dram_cmd        <= wr_reg ? CMD_WR : CMD_RD;
                    dram_addr       <= addr_reg;
                    cas_pending_reg <= 1'b1;
`ifdef LPDDR5_SCHED_CLOSED_PAGE_EN
                    ret_reg         <= S_PRE;
`else
                    ret_reg         <= S_IDLE;
`endif
                    wait_first_reg  <= 1'b1;
                    state_reg       <= S_WAIT;
                end
                S_RPRE: begin
                    dram_cmd                <= CMD_PRE;
                    dram_addr               <= {low_bank, {(ADDR_WIDTH-BANK_BITS){1'b0}}};
                    bank_open_reg[low_bank] <= 1'b0;
                    ret_reg                 <= ((bank_open_reg & ~low_mask) != '0) ? S_RPRE : S_REF;
                    wait_first_reg          <= 1'b1;
                    state_reg               <= S_WAIT;
                end
                S_REF: begin
                    dram_cmd       <= CMD_REF;
                    dram_addr      <= '0;
                    ret_reg        <= S_IDLE;
                    wait_first_reg <= 1'b1;
                    state_reg      <= S_WAIT;
                end
                S_WAIT: begin
                    // The DRAM only sees the command during this first cycle, so its ready is stale here.
                    dram_cmd <= CMD_NOP;
                    if (wait_first_reg) begin
                        wait_first_reg <= 1'b0;
                    end else if (dram_ready) begin
                        state_reg <= ret_reg;
                        if (cas_pending_reg) begin
                            rsp_valid       <= 1'b1;
                            rsp_write       <= wr_reg;
                            cas_pending_reg <= 1'b0;
                        end
                        if (ret_reg == S_IDLE) req_ready <= !ref_pending_next;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    dram_cmd  <= CMD_NOP;
                end
            endcase
        end
    end

endmodule
